rtc_alarm_clock: RTL and testbench
==================================

Name: rtc_alarm_clock

Overview:
Parametrised successor to the team's BCD real-time clock. It divides the system clock down to a 1 Hz tick and keeps HH:MM:SS in BCD, in either 24-hour or 12-hour (AM/PM) mode. It adds synchronous time-set with validity checking, a latched alarm with acknowledge, and seven-segment encoding of polarity selectable per board. It sits between the board clock and the display/LED driver logic.

Parameters:
CLK_DIV, 50000000, clk cycles per second tick (legal range 1..2^32-1; 1 = tick every cycle, for simulation)
MODE_12H, 0, 0 = 24-hour (00..23), 1 = 12-hour (12,01..11 plus pm flag)
SEG_ACTIVE_LOW, 1, 1 = segment on at 0 (team encoding, '0' = 0000001), 0 = all segment bits inverted

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
set_en  in  1  one-cycle strobe: load set_time/set_pm
set_time  in  24  BCD {hr_m,hr_l,min_m,min_l,sec_m,sec_l}
set_pm  in  1  pm flag for load (ignored when MODE_12H=0)
alarm_wr  in  1  one-cycle strobe: load alarm_time/alarm_pm
alarm_time  in  16  BCD {hr_m,hr_l,min_m,min_l}
alarm_pm  in  1  alarm pm flag (ignored when MODE_12H=0)
alarm_en  in  1  alarm arm level
alarm_ack  in  1  one-cycle strobe: clear alarm_ring
time_bcd  out  24  current time, same packing as set_time
pm  out  1  1 = PM (always 0 when MODE_12H=0)
sec_tick  out  1  one-cycle pulse on the cycle the time advances
set_err  out  1  one-cycle pulse: set_en or alarm_wr rejected
alarm_ring  out  1  latched alarm indication
seg  out  42  seven-seg {hr_m,hr_l,min_m,min_l,sec_m,sec_l}, 7 bits each, a..g MSB first

Behaviour:
- Reset (reset=0 at a clk edge) applies to all registers. 24h: time 00:00:00. 12h: time 12:00:00, pm=0. Also: prescaler=0, sec_tick=0, set_err=0, alarm_ring=0, alarm register 00:00 (12h: 12:00) with alarm pm=0.
- Prescaler: counts 0..CLK_DIV-1. At terminal count it wraps to 0 and asserts tick internally. sec_tick is registered and high during the same cycle the new time_bcd is visible.
- Advance on tick: sec_l 0..9, sec_m 0..5, min_l 0..9, min_m 0..5, each carrying to the next digit.
  - 24h: 23:59:59 -> 00:00:00.
  - 12h: 12:59:59 -> 01:00:00. 11:59:59 -> 12:00:00 with pm toggled. Hour 09 -> 10, 10 -> 11.
- Time set: on set_en, validate set_time. Each digit must be <=9. sec_m and min_m must be <=5. Hour must be 00..23 (24h) or 01..12 (12h).
  - Valid: time and pm load next cycle, prescaler clears to 0, no sec_tick that cycle.
  - Invalid: time unchanged, set_err pulses for 1 cycle.
- set_en and tick in the same cycle: set wins and the tick is discarded.
- Alarm write: on alarm_wr, alarm_time is validated with the same minute/hour rules. Invalid sets set_err and keeps the old alarm.
- set_en and alarm_wr may be asserted together. Each is validated independently, and set_err pulses if either one fails.
- Alarm match: alarm_ring sets when alarm_en=1 and the time becomes hh:mm:00 equal to the alarm register (pm included in 12h). The match is evaluated on the advancing tick only; a time-set landing on the alarm time does not ring.
- alarm_ring holds until alarm_ack=1 or alarm_en=0; it clears the next cycle.
- Match and alarm_ack in the same cycle: the match wins and alarm_ring stays 1.
- seg: combinational from the time registers. Digit table 0..9 matches the team's encoding; codes >9 blank (all off). With SEG_ACTIVE_LOW=0 every bit is inverted.
- Reset mid-count: the prescaler restarts from 0, so the first tick comes CLK_DIV cycles after reset deasserts.

Test Plan:
- 24h, CLK_DIV=1: set 23:59:58 -> two cycles later time_bcd=0x000000, sec_tick high each cycle.
- 12h, CLK_DIV=1: set 11:59:59 pm=0 -> next 0x120000, pm=1. Set 12:59:59 pm=1 -> next 0x010000, pm=1.
- Invalid sets: 0x240000 (24h), 0x000000 (12h), 0x006000 -> each gives a set_err pulse and time_bcd unchanged. Same-cycle set_en and tick -> loaded value shown, no advance.
- Alarm: alarm 0x0730, alarm_en=1, set 07:29:59, tick -> alarm_ring=1 at 07:30:00. alarm_ack -> 0 next cycle. Ack coinciding with match -> stays 1. alarm_en=0 -> never rings.
- CLK_DIV=4: sec_tick exactly every 4th cycle. A set mid-count restarts the 4-cycle spacing. reset low mid-run -> all outputs return to reset values the next edge.
- seg check: time 0x081234, SEG_ACTIVE_LOW=1 -> hr_m field 0000001, hr_l 0000000. Same time with SEG_ACTIVE_LOW=0 -> both fields bitwise inverted.

Source files
------------

// File: rtl/rtc_alarm_clock.sv
// BCD real-time clock with 1 Hz prescaler, 12/24-hour modes, validated time set,
// latched alarm with acknowledge and seven-segment encoding.
module rtc_alarm_clock #(
   parameter int unsigned CLK_DIV        = 50000000,
   parameter bit          MODE_12H       = 1'b0,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        set_en,
   input  logic [23:0] set_time,
   input  logic        set_pm,
   input  logic        alarm_wr,
   input  logic [15:0] alarm_time,
   input  logic        alarm_pm,
   input  logic        alarm_en,
   input  logic        alarm_ack,
   output logic [23:0] time_bcd,
   output logic        pm,
   output logic        sec_tick,
   output logic        set_err,
   output logic        alarm_ring,
   output logic [41:0] seg
);

   localparam logic [31:0] DIV_LAST  = CLK_DIV - 32'd1;
   localparam logic [23:0] TIME_RST  = MODE_12H ? 24'h120000 : 24'h000000;
   localparam logic [15:0] ALARM_RST = MODE_12H ? 16'h1200 : 16'h0000;

   logic [31:0] prescaler;
   logic [23:0] time_r;
   logic        pm_r;
   logic [15:0] alarm_r;
   logic        alarm_pm_r;
   logic        sec_tick_r;
   logic        set_err_r;
   logic        ring_r;

   logic        tick;
   logic        advance;
   logic        set_ok;
   logic        alarm_ok;
   logic        alarm_hit;
   logic [23:0] adv_time;
   logic        adv_pm;

   logic [3:0] hr_m, hr_l, min_m, min_l, sec_m, sec_l;
   logic       c_sec_l, c_sec_m, c_min_l, c_min_m;

   function automatic logic hour_ok(input logic [3:0] hm, input logic [3:0] hl);
      if (MODE_12H)
         return ((hm == 4'd0) && (hl >= 4'd1) && (hl <= 4'd9)) ||
                ((hm == 4'd1) && (hl <= 4'd2));
      else
         return ((hm <= 4'd1) && (hl <= 4'd9)) ||
                ((hm == 4'd2) && (hl <= 4'd3));
   endfunction

   function automatic logic hhmm_ok(input logic [15:0] t);
      return hour_ok(t[15:12], t[11:8]) && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
   endfunction

   function automatic logic [6:0] seg_digit(input logic [3:0] d);
      logic [6:0] code;
      case (d)
         4'd0:    code = 7'b0000001;
         4'd1:    code = 7'b1001111;
         4'd2:    code = 7'b0010010;
         4'd3:    code = 7'b0000110;
         4'd4:    code = 7'b1001100;
         4'd5:    code = 7'b0100100;
         4'd6:    code = 7'b0100000;
         4'd7:    code = 7'b0001111;
         4'd8:    code = 7'b0000000;
         4'd9:    code = 7'b0000100;
         default: code = 7'b1111111;
      endcase
      return SEG_ACTIVE_LOW ? code : ~code;
   endfunction

   assign {hr_m, hr_l, min_m, min_l, sec_m, sec_l} = time_r;

   assign tick     = (prescaler == DIV_LAST);
   assign advance  = tick && !set_en;
   assign set_ok   = hhmm_ok(set_time[23:8]) && (set_time[7:4] <= 4'd5) &&
                     (set_time[3:0] <= 4'd9);
   assign alarm_ok = hhmm_ok(alarm_time);

   assign c_sec_l = (sec_l == 4'd9);
   assign c_sec_m = c_sec_l && (sec_m == 4'd5);
   assign c_min_l = c_sec_m && (min_l == 4'd9);
   assign c_min_m = c_min_l && (min_m == 4'd5);

   // Next time value one second on; hour rollover differs between 12h and 24h.
   always_comb begin
      adv_time       = time_r;
      adv_pm         = pm_r;
      adv_time[3:0]  = c_sec_l ? 4'd0 : sec_l + 4'd1;
      if (c_sec_l)
         adv_time[7:4] = c_sec_m ? 4'd0 : sec_m + 4'd1;
      if (c_sec_m)
         adv_time[11:8] = c_min_l ? 4'd0 : min_l + 4'd1;
      if (c_min_l)
         adv_time[15:12] = c_min_m ? 4'd0 : min_m + 4'd1;
      if (c_min_m) begin
         if (MODE_12H) begin
            if ((hr_m == 4'd1) && (hr_l == 4'd2)) begin
               adv_time[23:16] = 8'h01;
            end else if ((hr_m == 4'd1) && (hr_l == 4'd1)) begin
               adv_time[23:16] = 8'h12;
               adv_pm          = ~pm_r;
            end else if (hr_l == 4'd9) begin
               adv_time[23:16] = 8'h10;
            end else begin
               adv_time[19:16] = hr_l + 4'd1;
            end
         end else begin
            if ((hr_m == 4'd2) && (hr_l == 4'd3)) begin
               adv_time[23:16] = 8'h00;
            end else if (hr_l == 4'd9) begin
               adv_time[23:20] = hr_m + 4'd1;
               adv_time[19:16] = 4'd0;
            end else begin
               adv_time[19:16] = hr_l + 4'd1;
            end
         end
      end
   end

   assign alarm_hit = alarm_en && (adv_time[7:0] == 8'h00) &&
                      (adv_time[23:8] == alarm_r) &&
                      (!MODE_12H || (adv_pm == alarm_pm_r));

   // A set strobe always swallows a coincident tick; only a valid set restarts the prescaler.
   always_ff @(posedge clk) begin
      if (!reset) begin
         prescaler  <= 32'd0;
         time_r     <= TIME_RST;
         pm_r       <= 1'b0;
         alarm_r    <= ALARM_RST;
         alarm_pm_r <= 1'b0;
         sec_tick_r <= 1'b0;
         set_err_r  <= 1'b0;
         ring_r     <= 1'b0;
      end else begin
         sec_tick_r <= advance;
         set_err_r  <= (set_en && !set_ok) || (alarm_wr && !alarm_ok);

         if (set_en && set_ok) begin
            prescaler <= 32'd0;
            time_r    <= set_time;
            pm_r      <= MODE_12H && set_pm;
         end else begin
            prescaler <= tick ? 32'd0 : prescaler + 32'd1;
            if (advance) begin
               time_r <= adv_time;
               pm_r   <= adv_pm;
            end
         end

         if (alarm_wr && alarm_ok) begin
            alarm_r    <= alarm_time;
            alarm_pm_r <= MODE_12H && alarm_pm;
         end

         if (advance && alarm_hit)
            ring_r <= 1'b1;
         else if (alarm_ack || !alarm_en)
            ring_r <= 1'b0;
      end
   end

   assign time_bcd   = time_r;
   assign pm         = MODE_12H && pm_r;
   assign sec_tick   = sec_tick_r;
   assign set_err    = set_err_r;
   assign alarm_ring = ring_r;
   assign seg        = {seg_digit(hr_m), seg_digit(hr_l), seg_digit(min_m),
                        seg_digit(min_l), seg_digit(sec_m), seg_digit(sec_l)};

endmodule

// File: tb/tb_rtc_alarm_clock.sv
// Directed bench for rtc_alarm_clock: three instances (24h fast, 12h fast, 24h /4 with
// active-high segments) share stimulus; expectations queue up and are checked after each edge.
module tb_rtc_alarm_clock;

   logic        clk = 1'b0;
   logic        reset;
   logic        set_en;
   logic [23:0] set_time;
   logic        set_pm;
   logic        alarm_wr;
   logic [15:0] alarm_time;
   logic        alarm_pm;
   logic        alarm_en;
   logic        alarm_ack;

   logic [23:0] a_time, b_time, c_time;
   logic        a_pm, b_pm, c_pm;
   logic        a_tick, b_tick, c_tick;
   logic        a_err, b_err, c_err;
   logic        a_ring, b_ring, c_ring;
   logic [41:0] a_seg, b_seg, c_seg;

   localparam int A_TIME = 0, A_PM = 1, A_TICK = 2, A_ERR = 3, A_RING = 4, A_SEG = 5;
   localparam int B_TIME = 10, B_PM = 11, B_TICK = 12, B_ERR = 13, B_RING = 14;
   localparam int C_TIME = 20, C_TICK = 22, C_SEG = 25;

   string       tag_q[$];
   int          sig_q[$];
   logic [47:0] exp_q[$];
   int          pass_count = 0;
   int          total_count = 0;

   logic [41:0] seg_zero;
   logic [41:0] seg_081234;

   always #5 clk = ~clk;

   rtc_alarm_clock #(.CLK_DIV(1), .MODE_12H(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut_a (
      .clk(clk), .reset(reset), .set_en(set_en), .set_time(set_time), .set_pm(set_pm),
      .alarm_wr(alarm_wr), .alarm_time(alarm_time), .alarm_pm(alarm_pm),
      .alarm_en(alarm_en), .alarm_ack(alarm_ack), .time_bcd(a_time), .pm(a_pm),
      .sec_tick(a_tick), .set_err(a_err), .alarm_ring(a_ring), .seg(a_seg));

   rtc_alarm_clock #(.CLK_DIV(1), .MODE_12H(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_b (
      .clk(clk), .reset(reset), .set_en(set_en), .set_time(set_time), .set_pm(set_pm),
      .alarm_wr(alarm_wr), .alarm_time(alarm_time), .alarm_pm(alarm_pm),
      .alarm_en(alarm_en), .alarm_ack(alarm_ack), .time_bcd(b_time), .pm(b_pm),
      .sec_tick(b_tick), .set_err(b_err), .alarm_ring(b_ring), .seg(b_seg));

   rtc_alarm_clock #(.CLK_DIV(4), .MODE_12H(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut_c (
      .clk(clk), .reset(reset), .set_en(set_en), .set_time(set_time), .set_pm(set_pm),
      .alarm_wr(alarm_wr), .alarm_time(alarm_time), .alarm_pm(alarm_pm),
      .alarm_en(alarm_en), .alarm_ack(alarm_ack), .time_bcd(c_time), .pm(c_pm),
      .sec_tick(c_tick), .set_err(c_err), .alarm_ring(c_ring), .seg(c_seg));

   function automatic logic [47:0] observe(input int sig);
      case (sig)
         A_TIME:  return {24'd0, a_time};
         A_PM:    return {47'd0, a_pm};
         A_TICK:  return {47'd0, a_tick};
         A_ERR:   return {47'd0, a_err};
         A_RING:  return {47'd0, a_ring};
         A_SEG:   return {6'd0, a_seg};
         B_TIME:  return {24'd0, b_time};
         B_PM:    return {47'd0, b_pm};
         B_TICK:  return {47'd0, b_tick};
         B_ERR:   return {47'd0, b_err};
         B_RING:  return {47'd0, b_ring};
         C_TIME:  return {24'd0, c_time};
         C_TICK:  return {47'd0, c_tick};
         C_SEG:   return {6'd0, c_seg};
         default: return 48'hDEAD_DEAD_DEAD;
      endcase
   endfunction

   task automatic expect_val(input string tag, input int sig, input logic [47:0] value);
      tag_q.push_back(tag);
      sig_q.push_back(sig);
      exp_q.push_back(value);
   endtask

   task automatic checkOutput();
      string       tag;
      int          sig;
      logic [47:0] want;
      logic [47:0] got;
      while (exp_q.size() > 0) begin
         tag  = tag_q.pop_front();
         sig  = sig_q.pop_front();
         want = exp_q.pop_front();
         got  = observe(sig);
         total_count++;
         assert (got === want) pass_count++;
         else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, want);
      end
   endtask

   task automatic applyStimulus(input logic s_en, input logic [23:0] s_time, input logic s_pm,
                                input logic a_wr, input logic [15:0] a_time_in,
                                input logic a_pm_in, input logic ack);
      set_en     = s_en;
      set_time   = s_time;
      set_pm     = s_pm;
      alarm_wr   = a_wr;
      alarm_time = a_time_in;
      alarm_pm   = a_pm_in;
      alarm_ack  = ack;
      @(posedge clk);
      #1;
      set_en    = 1'b0;
      alarm_wr  = 1'b0;
      alarm_ack = 1'b0;
      checkOutput();
   endtask

   task automatic idle();
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
   endtask

   task automatic set_clock(input logic [23:0] t, input logic p);
      applyStimulus(1'b1, t, p, 1'b0, 16'h0, 1'b0, 1'b0);
   endtask

   initial begin
      seg_zero   = {6{7'b0000001}};
      seg_081234 = {7'b0000001, 7'b0000000, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
      reset = 1'b0; set_en = 1'b0; set_time = 24'h0; set_pm = 1'b0;
      alarm_wr = 1'b0; alarm_time = 16'h0; alarm_pm = 1'b0; alarm_en = 1'b0; alarm_ack = 1'b0;

      // reset state
      expect_val("rst_a_time", A_TIME, 48'h000000);
      expect_val("rst_a_pm",   A_PM,   48'h0);
      expect_val("rst_a_tick", A_TICK, 48'h0);
      expect_val("rst_a_err",  A_ERR,  48'h0);
      expect_val("rst_a_ring", A_RING, 48'h0);
      expect_val("rst_a_seg",  A_SEG,  {6'd0, seg_zero});
      expect_val("rst_b_time", B_TIME, 48'h120000);
      expect_val("rst_b_pm",   B_PM,   48'h0);
      expect_val("rst_c_time", C_TIME, 48'h000000);
      expect_val("rst_c_tick", C_TICK, 48'h0);
      expect_val("rst_c_seg",  C_SEG,  {6'd0, ~seg_zero});
      idle();
      reset = 1'b1;

      // divide-by-4 spacing from reset release
      for (int k = 1; k <= 8; k++) begin
         expect_val("div4_tick", C_TICK, {47'd0, (k % 4) == 0});
         if (k == 8) begin
            expect_val("div4_time", C_TIME, 48'h000002);
            expect_val("run_a_time", A_TIME, 48'h000008);
            expect_val("run_b_time", B_TIME, 48'h120008);
         end
         idle();
      end

      // 24h midnight rollover; 23:xx is illegal for the 12h instance
      expect_val("set_a_time", A_TIME, 48'h235958);
      expect_val("set_a_tick", A_TICK, 48'h0);
      expect_val("set_a_err",  A_ERR,  48'h0);
      expect_val("bad23_b_err", B_ERR, 48'h1);
      expect_val("bad23_b_time", B_TIME, 48'h120008);
      expect_val("set_c_time", C_TIME, 48'h235958);
      expect_val("set_c_tick", C_TICK, 48'h0);
      set_clock(24'h235958, 1'b0);
      expect_val("roll_a_59", A_TIME, 48'h235959);
      expect_val("roll_a_tick1", A_TICK, 48'h1);
      expect_val("err_pulse_b", B_ERR, 48'h0);
      idle();
      expect_val("roll_a_00", A_TIME, 48'h000000);
      expect_val("roll_a_tick2", A_TICK, 48'h1);
      expect_val("roll_a_seg", A_SEG, {6'd0, seg_zero});
      idle();
      expect_val("c_after_set3", C_TICK, 48'h0);
      idle();
      expect_val("c_after_set4", C_TICK, 48'h1);
      expect_val("c_after_time", C_TIME, 48'h235959);
      idle();
      idle();
      idle();

      // set mid-count restarts /4 spacing; coincident tick is dropped
      expect_val("mid_a_time", A_TIME, 48'h101010);
      expect_val("mid_a_tick", A_TICK, 48'h0);
      expect_val("mid_b_time", B_TIME, 48'h101010);
      expect_val("mid_b_tick", B_TICK, 48'h0);
      expect_val("mid_c_time", C_TIME, 48'h101010);
      set_clock(24'h101010, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         expect_val("mid_c_tick", C_TICK, {47'd0, k == 4});
         if (k == 1) expect_val("mid_a_next", A_TIME, 48'h101011);
         if (k == 4) expect_val("mid_c_next", C_TIME, 48'h101011);
         idle();
      end

      // 12h rollovers
      expect_val("h12_set_time", B_TIME, 48'h115959);
      expect_val("h12_set_pm",   B_PM,   48'h0);
      expect_val("h12_set_err",  B_ERR,  48'h0);
      set_clock(24'h115959, 1'b0);
      expect_val("h12_noon_time", B_TIME, 48'h120000);
      expect_val("h12_noon_pm",   B_PM,   48'h1);
      expect_val("h12_noon_tick", B_TICK, 48'h1);
      idle();
      expect_val("h12_set2_time", B_TIME, 48'h125959);
      expect_val("h12_set2_pm",   B_PM,   48'h1);
      expect_val("h24_pm_ignored", A_PM, 48'h0);
      expect_val("h24_set_1259", A_TIME, 48'h125959);
      set_clock(24'h125959, 1'b1);
      expect_val("h12_one_time", B_TIME, 48'h010000);
      expect_val("h12_one_pm",   B_PM,   48'h1);
      expect_val("h24_1300", A_TIME, 48'h130000);
      idle();

      // invalid sets leave time untouched and pulse set_err
      expect_val("bad24_a_err",  A_ERR,  48'h1);
      expect_val("bad24_a_time", A_TIME, 48'h130000);
      expect_val("bad24_b_err",  B_ERR,  48'h1);
      expect_val("bad24_b_time", B_TIME, 48'h010000);
      set_clock(24'h240000, 1'b0);
      expect_val("zero_a_err",  A_ERR,  48'h0);
      expect_val("zero_a_time", A_TIME, 48'h000000);
      expect_val("bad00_b_err", B_ERR,  48'h1);
      expect_val("bad00_b_time", B_TIME, 48'h010000);
      expect_val("bad00_b_pm",  B_PM,   48'h1);
      set_clock(24'h000000, 1'b0);
      expect_val("bad60_a_err",  A_ERR,  48'h1);
      expect_val("bad60_a_time", A_TIME, 48'h000000);
      set_clock(24'h006000, 1'b0);
      expect_val("bad60_err_clr", A_ERR, 48'h0);
      expect_val("bad60_resume", A_TIME, 48'h000001);
      idle();

      // alarm ring and acknowledge
      alarm_en = 1'b1;
      expect_val("alw_a_err",  A_ERR,  48'h0);
      expect_val("alw_a_ring", A_RING, 48'h0);
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b1, 16'h0730, 1'b0, 1'b0);
      expect_val("al_set_time", A_TIME, 48'h072959);
      expect_val("al_set_ring", A_RING, 48'h0);
      expect_val("al_set_bring", B_RING, 48'h0);
      set_clock(24'h072959, 1'b0);
      expect_val("al_hit_time", A_TIME, 48'h073000);
      expect_val("al_hit_ring", A_RING, 48'h1);
      expect_val("al_hit_btime", B_TIME, 48'h073000);
      expect_val("al_hit_bpm", B_PM, 48'h0);
      expect_val("al_hit_bring", B_RING, 48'h1);
      idle();
      expect_val("al_hold", A_RING, 48'h1);
      idle();
      expect_val("al_ack_a", A_RING, 48'h0);
      expect_val("al_ack_b", B_RING, 48'h0);
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

      // ack coinciding with the match loses
      expect_val("alc_set_ring", A_RING, 48'h0);
      set_clock(24'h072959, 1'b0);
      expect_val("alc_match_ack", A_RING, 48'h1);
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      expect_val("alc_hold", A_RING, 48'h1);
      idle();
      alarm_en = 1'b0;
      expect_val("alc_en_clear", A_RING, 48'h0);
      idle();

      // disarmed alarm never rings
      set_clock(24'h072959, 1'b0);
      expect_val("dis_time", A_TIME, 48'h073000);
      expect_val("dis_a_ring", A_RING, 48'h0);
      expect_val("dis_b_ring", B_RING, 48'h0);
      idle();

      // rejected alarm write keeps the previous 07:30 alarm
      expect_val("badal_a_err", A_ERR, 48'h1);
      expect_val("badal_b_err", B_ERR, 48'h1);
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b1, 16'h0760, 1'b0, 1'b0);
      alarm_en = 1'b1;
      set_clock(24'h072959, 1'b0);
      expect_val("badal_kept", A_RING, 48'h1);
      idle();

      // segment encoding in both polarities
      expect_val("seg_a_time", A_TIME, 48'h081234);
      expect_val("seg_a_low",  A_SEG, {6'd0, seg_081234});
      expect_val("seg_c_high", C_SEG, {6'd0, ~seg_081234});
      set_clock(24'h081234, 1'b0);
      idle();

      // reset mid-run with the alarm still ringing
      reset = 1'b0;
      expect_val("mrst_a_time", A_TIME, 48'h000000);
      expect_val("mrst_a_ring", A_RING, 48'h0);
      expect_val("mrst_a_tick", A_TICK, 48'h0);
      expect_val("mrst_a_err",  A_ERR,  48'h0);
      expect_val("mrst_b_time", B_TIME, 48'h120000);
      expect_val("mrst_b_pm",   B_PM,   48'h0);
      expect_val("mrst_b_ring", B_RING, 48'h0);
      expect_val("mrst_c_time", C_TIME, 48'h000000);
      expect_val("mrst_c_tick", C_TICK, 48'h0);
      idle();
      reset = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         expect_val("mrst_c_spacing", C_TICK, {47'd0, k == 4});
         if (k == 4) expect_val("mrst_c_first", C_TIME, 48'h000001);
         idle();
      end

      $display("[TB] %0d/%0d checks passed", pass_count, total_count);
      $finish;
   end

endmodule
